// File: rtl/gate_pkg.sv
// Shared types and the gate operation for the gate-array pipeline.
//   gate_op_e : 3-bit operation select carried on in_op
//   gate_eval : one bit lane of the selected operation. Every op is bitwise,
//               so the array is built by applying this to each lane, which
//               keeps the function independent of the WIDTH parameter.
package gate_pkg;

    typedef enum logic [2:0] {
        OP_AND   = 3'd0,
        OP_OR    = 3'd1,
        OP_NAND  = 3'd2,
        OP_NOR   = 3'd3,
        OP_XOR   = 3'd4,
        OP_XNOR  = 3'd5,
        OP_NOT_A = 3'd6,
        OP_BUF   = 3'd7
    } gate_op_e;

    function automatic logic gate_eval(input logic a, input logic b, input gate_op_e op);
        logic y;
        case (op)
            OP_AND:   y = a & b;
            OP_OR:    y = a | b;
            OP_NAND:  y = ~(a & b);
            OP_NOR:   y = ~(a | b);
            OP_XOR:   y = a ^ b;
            OP_XNOR:  y = ~(a ^ b);
            OP_NOT_A: y = ~a;
            default:  y = a;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/gate_pipe_stage.sv
// One elastic register stage of the gate-array pipeline.
//   clk, rst_n         : clock, synchronous active-low reset
//   rdy_i              : load enable (this stage is empty or downstream takes)
//   v_i, y_i, any_i,
//   all_i              : upstream beat; v_i=0 loads a bubble
//   v_o, y_o, any_o,
//   all_o              : registered beat held for the next stage / output
module gate_pipe_stage
    import gate_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rdy_i,
    input  logic             v_i,
    input  logic [WIDTH-1:0] y_i,
    input  logic             any_i,
    input  logic             all_i,
    output logic             v_o,
    output logic [WIDTH-1:0] y_o,
    output logic             any_o,
    output logic             all_o
);

    logic             v_q,   v_d;
    logic [WIDTH-1:0] y_q,   y_d;
    logic             any_q, any_d;
    logic             all_q, all_d;

    always_comb begin
        v_d   = v_q;
        y_d   = y_q;
        any_d = any_q;
        all_d = all_q;
        if (rdy_i) begin
            v_d   = v_i;
            y_d   = y_i;
            any_d = any_i;
            all_d = all_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q   <= 1'b0;
            y_q   <= '0;
            any_q <= 1'b0;
            all_q <= 1'b0;
        end else begin
            v_q   <= v_d;
            y_q   <= y_d;
            any_q <= any_d;
            all_q <= all_d;
        end
    end

    assign v_o   = v_q;
    assign y_o   = y_q;
    assign any_o = any_q;
    assign all_o = all_q;

endmodule

// File: rtl/gate_array_pipe.sv
// WIDTH-bit bitwise gate array with runtime op select, a STAGES-deep elastic
// valid/ready pipeline, registered reductions of the result and a delivered
// beat counter.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : input handshake
//   in_a, in_b, in_op   : operands and gate_op_e select
//   out_valid/out_ready : output handshake
//   out_y               : bitwise result
//   out_any, out_all    : |out_y and &out_y
//   out_cnt             : delivered beats, wraps at 2^CNT_W
module gate_array_pipe
    import gate_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_any,
    output logic             out_all,
    output logic [CNT_W-1:0] out_cnt
);

    gate_op_e         op;
    logic [WIDTH-1:0] eval_y;
    logic             eval_any;
    logic             eval_all;

    assign op = gate_op_e'(in_op);

    always_comb begin
        eval_y = '0;
        for (int j = 0; j < WIDTH; j++) begin
            eval_y[j] = gate_eval(in_a[j], in_b[j], op);
        end
    end

    // Reductions are taken before stage 0 so they travel with y and cost
    // no extra cycle at the output.
    assign eval_any = |eval_y;
    assign eval_all = &eval_y;

    logic [STAGES-1:0] v_s;
    logic [STAGES-1:0] any_s;
    logic [STAGES-1:0] all_s;
    logic [WIDTH-1:0]  y_s [STAGES];
    logic [STAGES:0]   rdy;

    // Ready propagates backwards; an empty stage is always ready, which is
    // what lets bubbles collapse while the sink is stalled.
    always_comb begin
        rdy         = '0;
        rdy[STAGES] = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            rdy[i] = !v_s[i] || rdy[i+1];
        end
    end

    assign in_ready = rdy[0];

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic             v_in;
        logic [WIDTH-1:0] y_in;
        logic             any_in;
        logic             all_in;

        if (i == 0) begin : g_head
            // Only in_valid feeds the valid bit, so unknown operands while
            // idle cannot corrupt pipeline occupancy.
            assign v_in   = in_valid;
            assign y_in   = eval_y;
            assign any_in = eval_any;
            assign all_in = eval_all;
        end else begin : g_body
            assign v_in   = v_s[i-1];
            assign y_in   = y_s[i-1];
            assign any_in = any_s[i-1];
            assign all_in = all_s[i-1];
        end

        gate_pipe_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk   (clk),
            .rst_n (rst_n),
            .rdy_i (rdy[i]),
            .v_i   (v_in),
            .y_i   (y_in),
            .any_i (any_in),
            .all_i (all_in),
            .v_o   (v_s[i]),
            .y_o   (y_s[i]),
            .any_o (any_s[i]),
            .all_o (all_s[i])
        );
    end

    assign out_valid = v_s[STAGES-1];
    assign out_y     = y_s[STAGES-1];
    assign out_any   = any_s[STAGES-1];
    assign out_all   = all_s[STAGES-1];

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (out_valid && out_ready) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign out_cnt = cnt_q;

endmodule
